// File: rtl/sc_window_sequencer_if.sv
// sc_window_sequencer_if
//
// Purpose: bundles the host-side controls and the datapath-side signals of
// sc_window_sequencer so the sequencer, its host and its datapath connect
// through one object.
//
// Optional feature macro: SC_BIPOLAR_DECODE_EN adds result_bip.
//
// Signals (direction as seen from the sequencer, modport slave):
//   in  start, abort, win_log2[2:0], prob_a[3:0], prob_b[3:0], sn_in
//   out prob_a_q[3:0], prob_b_q[3:0], seed_a[30:0], seed_b[30:0],
//       lfsr_load, lfsr_en, busy, done, result[CNT_W-1:0], state_dbg[2:0]
//   out result_bip[CNT_W:0] (signed, only with SC_BIPOLAR_DECODE_EN)
//
// Handshake: start is a request honoured only while busy=0 (IDLE); once
// accepted, busy stays high until the cycle after the one-cycle done pulse,
// and result is valid from the done cycle until the next done. abort
// cancels any busy run without a done pulse.
interface sc_window_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic [2:0]       win_log2;
  logic [3:0]       prob_a;
  logic [3:0]       prob_b;
  logic             sn_in;
  logic [3:0]       prob_a_q;
  logic [3:0]       prob_b_q;
  logic [30:0]      seed_a;
  logic [30:0]      seed_b;
  logic             lfsr_load;
  logic             lfsr_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] result;
  logic [2:0]       state_dbg;
`ifdef SC_BIPOLAR_DECODE_EN
  logic signed [CNT_W:0] result_bip;

  modport master (
    output start, abort, win_log2, prob_a, prob_b, sn_in,
    input  prob_a_q, prob_b_q, seed_a, seed_b, lfsr_load, lfsr_en,
           busy, done, result, state_dbg, result_bip
  );

  modport slave (
    input  start, abort, win_log2, prob_a, prob_b, sn_in,
    output prob_a_q, prob_b_q, seed_a, seed_b, lfsr_load, lfsr_en,
           busy, done, result, state_dbg, result_bip
  );
`else
  modport master (
    output start, abort, win_log2, prob_a, prob_b, sn_in,
    input  prob_a_q, prob_b_q, seed_a, seed_b, lfsr_load, lfsr_en,
           busy, done, result, state_dbg
  );

  modport slave (
    input  start, abort, win_log2, prob_a, prob_b, sn_in,
    output prob_a_q, prob_b_q, seed_a, seed_b, lfsr_load, lfsr_en,
           busy, done, result, state_dbg
  );
`endif
endinterface

// File: rtl/sc_window_sequencer.sv
// sc_window_sequencer
//
// Purpose: sequences one stochastic-multiply evaluation on an external
// LFSR/comparator/XNOR datapath: seed the LFSRs (LOAD), let the datapath
// pipeline fill (FILL, PIPE_LAT cycles), count ones in sn_in over a window
// of N = 2^win_log2 bits (RUN), then pulse done with the popcount (DONE).
// Operands and window size are latched when a run is accepted.
//
// Optional feature macro: SC_BIPOLAR_DECODE_EN adds result_bip = 2*ones - N.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous reset, active high (legacy name)
//   bus    sc_window_sequencer_if.slave (host controls, datapath controls,
//          status, result, state_dbg exposes the FSM state)
//
// PIPE_LAT must be at least 1.
module sc_window_sequencer #(
  parameter int          CNT_W    = 8,
  parameter int          PIPE_LAT = 2,
  parameter logic [30:0] SEED_A   = 31'd1,
  parameter logic [30:0] SEED_B   = 31'd2
) (
  input logic                  clk,
  input logic                  rst_n,
  sc_window_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_FILL = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // Largest window exponent that keeps the ones count from wrapping.
  localparam int         MAX_LOG2  = CNT_W - 1;
  localparam logic [2:0] WL_MAX    = (MAX_LOG2 > 7) ? 3'd7 : 3'(MAX_LOG2);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(PIPE_LAT - 1);

  state_e           state_q, state_d;
  logic [3:0]       pa_q, pa_d;
  logic [3:0]       pb_q, pb_d;
  logic [2:0]       wl_q, wl_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;   // shared by FILL and RUN
  logic [CNT_W-1:0] res_q, res_d;

  logic [2:0]       wl_clamped;
  logic [CNT_W-1:0] win_last;
  logic [CNT_W-1:0] ones_next;

`ifdef SC_BIPOLAR_DECODE_EN
  logic [CNT_W:0]   bip_q, bip_d;
  logic [CNT_W-1:0] n_val;
  logic [CNT_W:0]   bip_calc;
`endif

  always_comb begin
    wl_clamped = (bus.win_log2 > WL_MAX) ? WL_MAX : bus.win_log2;
    win_last   = (CNT_W'(1) << wl_q) - CNT_W'(1);
    // Includes the sample taken in the current RUN cycle, so the last
    // RUN sample reaches result on entry to DONE.
    ones_next  = ones_q + CNT_W'(bus.sn_in);
`ifdef SC_BIPOLAR_DECODE_EN
    n_val      = CNT_W'(1) << wl_q;
    // 2*ones may equal 2^CNT_W; modular subtraction still lands on the
    // correct two's-complement value in -N..+N.
    bip_calc   = {ones_next, 1'b0} - {1'b0, n_val};
`endif
  end

  always_comb begin
    state_d = state_q;
    pa_d    = pa_q;
    pb_d    = pb_q;
    wl_d    = wl_q;
    ones_d  = ones_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
`ifdef SC_BIPOLAR_DECODE_EN
    bip_d   = bip_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          pa_d    = bus.prob_a;
          pb_d    = bus.prob_b;
          wl_d    = wl_clamped;
          ones_d  = '0;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_FILL;
      end
      S_FILL: begin
        if (cnt_q == FILL_LAST) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        ones_d = ones_next;
        if (cnt_q == win_last) begin
          res_d   = ones_next;
`ifdef SC_BIPOLAR_DECODE_EN
          bip_d   = bip_calc;
`endif
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything outside IDLE and keeps the last result.
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      res_d   = res_q;
`ifdef SC_BIPOLAR_DECODE_EN
      bip_d   = bip_q;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      pa_q    <= '0;
      pb_q    <= '0;
      wl_q    <= '0;
      ones_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
`ifdef SC_BIPOLAR_DECODE_EN
      bip_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      wl_q    <= wl_d;
      ones_q  <= ones_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
`ifdef SC_BIPOLAR_DECODE_EN
      bip_q   <= bip_d;
`endif
    end
  end

  // Control outputs decode directly from the registered state.
  assign bus.lfsr_load = (state_q == S_LOAD);
  assign bus.lfsr_en   = (state_q == S_FILL) || (state_q == S_RUN);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.result    = res_q;
  assign bus.prob_a_q  = pa_q;
  assign bus.prob_b_q  = pb_q;
  assign bus.seed_a    = SEED_A;
  assign bus.seed_b    = SEED_B;
  assign bus.state_dbg = state_q;
`ifdef SC_BIPOLAR_DECODE_EN
  assign bus.result_bip = bip_q;
`endif

endmodule

// File: tb/tb_sc_window_sequencer.sv
// tb_sc_window_sequencer
//
// Directed bench for sc_window_sequencer (CNT_W=8, PIPE_LAT=2) plus a
// second instance with CNT_W=4 for the window clamp. Expected results come
// from the bench's own sn_in patterns and cycle arithmetic.
module tb_sc_window_sequencer;

  localparam int CNT_W = 8;
  localparam int PL    = 2;

  logic clk;
  logic rst_n;

  int checks;
  int failures;

  logic [CNT_W-1:0] exp_q[$];

  sc_window_sequencer_if #(.CNT_W(CNT_W)) bus ();
  sc_window_sequencer_if #(.CNT_W(4))     bus4 ();

  sc_window_sequencer #(.CNT_W(CNT_W), .PIPE_LAT(PL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  sc_window_sequencer #(.CNT_W(4), .PIPE_LAT(PL)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the next queued result.
  always @(negedge clk) begin
    if (!rst_n && bus.done) begin
      if (exp_q.size() == 0) chk("unexpected_done", 32'(bus.done), 32'd0);
      else                   chk("sb_result", 32'(bus.result), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- stimulus helpers ----------------
  // 0: all ones, 1: 1,0,1,0..., 2: ones at idx 0-1, 3: ones at idx 0-2
  function automatic logic pat(input int mode, input int i);
    case (mode)
      0:       return 1'b1;
      1:       return (i % 2) == 0;
      2:       return i < 2;
      default: return i < 3;
    endcase
  endfunction

  // Called at a negedge with the DUT in IDLE; returns at the negedge of the
  // first IDLE cycle after the run, so a following call starts back-to-back.
  task automatic run_window(input logic [2:0] wl, input int n, input int mode,
                            input int abort_at, input logic noise,
                            input logic [3:0] pa, input logic [3:0] pb);
    int ones_exp;
    int done_cyc;
    int run_idx;
    ones_exp = 0;
    for (int i = 0; i < n; i++) ones_exp += int'(pat(mode, i));
    if (abort_at < 0) exp_q.push_back(CNT_W'(ones_exp));
    done_cyc = 2 + PL + n;

    bus.start    = 1'b1;
    bus.win_log2 = wl;
    bus.prob_a   = pa;
    bus.prob_b   = pb;
    bus.abort    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;

    for (int cyc = 1; cyc <= done_cyc + 1; cyc++) begin
      chk("lfsr_load", 32'(bus.lfsr_load), 32'(cyc == 1));
      chk("lfsr_en",   32'(bus.lfsr_en),   32'(cyc >= 2 && cyc <= done_cyc - 1));
      chk("done",      32'(bus.done),      32'(cyc == done_cyc));
      chk("busy",      32'(bus.busy),      32'(cyc <= done_cyc));
      chk("prob_a_q",  32'(bus.prob_a_q),  32'(pa));
      chk("prob_b_q",  32'(bus.prob_b_q),  32'(pb));
      if (cyc == done_cyc) begin
        chk("result", 32'(bus.result), 32'(ones_exp));
`ifdef SC_BIPOLAR_DECODE_EN
        chk("result_bip", 32'(int'(bus.result_bip)), 32'(2 * ones_exp - n));
`endif
      end
      if (cyc == done_cyc + 1) begin
        bus.start  = 1'b0;
        bus.prob_a = pa;
        bus.sn_in  = 1'b0;
        break;
      end
      run_idx   = cyc - (2 + PL);
      bus.sn_in = (run_idx >= 0 && run_idx < n) ? pat(mode, run_idx)
                                                : 1'($urandom_range(0, 1));
      if (noise) begin
        bus.start  = (cyc >= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.prob_a = (cyc >= 3) ? 4'hA : pa;
      end
      if (abort_at >= 0 && run_idx == abort_at) bus.abort = 1'b1;
      @(negedge clk);
      if (bus.abort) begin
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("abort_busy", 32'(bus.busy),    32'd0);
        chk("abort_done", 32'(bus.done),    32'd0);
        chk("abort_en",   32'(bus.lfsr_en), 32'd0);
        break;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [CNT_W-1:0] prev;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    bus.start = 1'b0;  bus.abort = 1'b0;  bus.win_log2 = 3'd0;
    bus.prob_a = 4'h0; bus.prob_b = 4'h0; bus.sn_in = 1'b0;
    bus4.start = 1'b0; bus4.abort = 1'b0; bus4.win_log2 = 3'd0;
    bus4.prob_a = 4'h0; bus4.prob_b = 4'h0; bus4.sn_in = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_busy",   32'(bus.busy),      32'd0);
    chk("rst_done",   32'(bus.done),      32'd0);
    chk("rst_load",   32'(bus.lfsr_load), 32'd0);
    chk("rst_en",     32'(bus.lfsr_en),   32'd0);
    chk("rst_result", 32'(bus.result),    32'd0);
    chk("rst_pa",     32'(bus.prob_a_q),  32'd0);
    chk("rst_state",  32'(bus.state_dbg), 32'd0);
    chk("seed_a",     32'(bus.seed_a),    32'd1);
    chk("seed_b",     32'(bus.seed_b),    32'd2);
    rst_n = 1'b0;
    @(negedge clk);

    // N=8 all ones -> 8, done in cycle 12
    run_window(3'd3, 8, 0, -1, 1'b0, 4'h3, 4'hC);
    // N=16 toggling -> 8, done in cycle 20 (back-to-back start)
    run_window(3'd4, 16, 1, -1, 1'b0, 4'h7, 4'h1);
    // N=128 all ones -> 128, no wrap
    run_window(3'd7, 128, 0, -1, 1'b0, 4'h9, 4'h2);
    // N=8, two ones -> 2 (bipolar -4)
    run_window(3'd3, 8, 2, -1, 1'b0, 4'h4, 4'h4);
    // N=8, three ones -> 3, then abort in RUN cycle 5
    run_window(3'd3, 8, 3, -1, 1'b0, 4'h6, 4'h6);
    run_window(3'd3, 8, 0, 4, 1'b0, 4'h8, 4'h8);
    chk("abort_keeps_result", 32'(bus.result), 32'd3);
    repeat (2) @(negedge clk);
    chk("abort_no_restart", 32'(bus.busy), 32'd0);
    // new start after abort completes normally
    run_window(3'd3, 8, 1, -1, 1'b0, 4'h2, 4'h3);
    // stray starts and prob_a change mid-run are ignored
    run_window(3'd2, 4, 1, -1, 1'b1, 4'h5, 4'hB);
    @(negedge clk);
    chk("noise_no_restart", 32'(bus.busy), 32'd0);
    chk("noise_pa_hold",    32'(bus.prob_a_q), 32'h5);

    // asynchronous reset in the middle of RUN
    prev = bus.result;
    chk("pre_reset_result_nonzero", 32'(prev != 0), 32'd1);
    bus.start = 1'b1; bus.win_log2 = 3'd3; bus.prob_a = 4'hE; bus.prob_b = 4'hD;
    bus.sn_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_reset_run", 32'(bus.state_dbg), 32'd3);
    rst_n = 1'b1;
    #1;
    chk("arst_busy",   32'(bus.busy),      32'd0);
    chk("arst_en",     32'(bus.lfsr_en),   32'd0);
    chk("arst_done",   32'(bus.done),      32'd0);
    chk("arst_result", 32'(bus.result),    32'd0);
    chk("arst_pa",     32'(bus.prob_a_q),  32'd0);
    chk("arst_pb",     32'(bus.prob_b_q),  32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    bus.sn_in = 1'b0;
    @(negedge clk);

    // CNT_W=4: win_log2=7 clamps to N=8, all ones -> 8, done in cycle 12
    bus4.start = 1'b1; bus4.win_log2 = 3'd7; bus4.sn_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus4.start = 1'b0;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      chk("clamp_done", 32'(bus4.done), 32'(cyc == 12));
      if (cyc == 12) chk("clamp_result", 32'(bus4.result), 32'd8);
      if (cyc == 13) chk("clamp_busy", 32'(bus4.busy), 32'd0);
      else           @(negedge clk);
    end

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
